// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared JPEG header-parsing types and constants.
// Holds the DHT parser state encoding, the table-geometry defaults
// and the DHT marker value.
package jpeg_pkg;

  // Parser states for the DHT segment walker.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_TCTH   = 3'd3,
    ST_COUNTS = 3'd4,
    ST_VALS   = 3'd5,
    ST_HOLD   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam int JPEG_NUM_LEN  = 16;   // BITS entries per table (code lengths 1..16)
  localparam int JPEG_MAX_VALS = 162;  // largest legal HUFFVAL list (baseline AC)

  localparam logic [7:0] DHT_MARKER = 8'hC4;  // second byte of the FFC4 marker

endpackage

// File: rtl/jpeg_dht_parser.sv
// jpeg_dht_parser: walks a DHT segment byte stream and captures one Huffman
// table at a time (Tc/Th, 16 BITS counts, HUFFVAL list) into register arrays.
// Ports: clk/rst_n; seg_start pulse + byte_in/byte_valid/byte_ready stream in;
// huff_count_out/huff_val_out/tbl_class/tbl_id/tbl_valid table out, released
// by tbl_ack; seg_done pulse at segment end; err sticky malformed flag.
module jpeg_dht_parser
  import jpeg_pkg::*;
#(
  parameter int MAX_VALS = JPEG_MAX_VALS,
  parameter int NUM_LEN  = JPEG_NUM_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seg_start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [NUM_LEN-1:0][7:0]  huff_count_out,
  output logic [MAX_VALS-1:0][7:0] huff_val_out,
  output logic                     tbl_class,
  output logic [1:0]               tbl_id,
  output logic                     tbl_valid,
  input  logic                     tbl_ack,
  output logic                     seg_done,
  output logic                     err
);

  localparam int CW = $clog2(NUM_LEN);
  localparam int VW = $clog2(MAX_VALS);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_len_hi;
  logic [15:0]               r_remaining;
  logic [11:0]               r_total;
  logic [VW-1:0]             r_idx;
  logic [NUM_LEN-1:0][7:0]   r_counts;
  logic [MAX_VALS-1:0][7:0]  r_vals;
  logic                      r_class;
  logic [1:0]                r_id;
  logic                      r_seg_done;
  logic                      r_err;

  logic                      w_xfer;
  logic                      w_rem_nz;
  logic [15:0]               w_lh;
  logic [11:0]               w_total_nxt;
  logic                      w_last_cnt;
  logic                      w_last_val;
  logic                      w_tcth_ok;
  logic                      w_seg_done_set;

  // seg_start wins over everything, so no byte is taken in its cycle.
  assign byte_ready = !seg_start &&
                      (r_state inside {ST_LEN_HI, ST_LEN_LO, ST_TCTH,
                                       ST_COUNTS, ST_VALS, ST_ERROR});
  assign w_xfer      = byte_valid && byte_ready;
  assign w_rem_nz    = (r_remaining != 16'd0);
  assign w_lh        = {r_len_hi, byte_in};
  assign w_total_nxt = r_total + {4'd0, byte_in};
  assign w_last_cnt  = (r_idx == VW'(NUM_LEN - 1));
  assign w_last_val  = (12'(r_idx) == r_total - 12'd1);
  assign w_tcth_ok   = (byte_in[7:5] == 3'd0) && (byte_in[3:2] == 2'd0);

  assign huff_count_out = r_counts;
  assign huff_val_out   = r_vals;
  assign tbl_class      = r_class;
  assign tbl_id         = r_id;
  assign tbl_valid      = (r_state == ST_HOLD);
  assign seg_done       = r_seg_done;
  assign err            = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Inside a table, remaining==0 while a byte is still owed means the
  // segment length was too short for the table it claims to contain.
  always_comb begin
    w_state_nxt    = r_state;
    w_seg_done_set = 1'b0;
    if (seg_start) begin
      w_state_nxt = ST_LEN_HI;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_IDLE;
        ST_LEN_HI: if (w_xfer) w_state_nxt = ST_LEN_LO;
        ST_LEN_LO: if (w_xfer) begin
          if (w_lh < 16'd2) begin
            w_state_nxt = ST_ERROR;
          end else if (w_lh == 16'd2) begin
            w_state_nxt    = ST_IDLE;
            w_seg_done_set = 1'b1;
          end else begin
            w_state_nxt = ST_TCTH;
          end
        end
        ST_TCTH: begin
          if (!w_rem_nz)   w_state_nxt = ST_ERROR;
          else if (w_xfer) w_state_nxt = w_tcth_ok ? ST_COUNTS : ST_ERROR;
        end
        ST_COUNTS: begin
          if (!w_rem_nz) begin
            w_state_nxt = ST_ERROR;
          end else if (w_xfer && w_last_cnt) begin
            if (w_total_nxt > 12'(MAX_VALS)) w_state_nxt = ST_ERROR;
            else if (w_total_nxt == 12'd0)   w_state_nxt = ST_HOLD;
            else                             w_state_nxt = ST_VALS;
          end
        end
        ST_VALS: begin
          if (!w_rem_nz)                  w_state_nxt = ST_ERROR;
          else if (w_xfer && w_last_val)  w_state_nxt = ST_HOLD;
        end
        ST_HOLD: if (tbl_ack) begin
          if (w_rem_nz) begin
            w_state_nxt = ST_TCTH;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_seg_done_set = 1'b1;
          end
        end
        ST_ERROR: w_state_nxt = ST_ERROR;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi    <= '0;
      r_remaining <= '0;
      r_total     <= '0;
      r_idx       <= '0;
      r_counts    <= '0;
      r_vals      <= '0;
      r_class     <= 1'b0;
      r_id        <= '0;
      r_seg_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_seg_done <= w_seg_done_set;
      if (seg_start)                    r_err <= 1'b0;
      else if (w_state_nxt == ST_ERROR) r_err <= 1'b1;

      if (w_xfer) begin
        case (r_state)
          ST_LEN_HI: r_len_hi <= byte_in;
          ST_LEN_LO: r_remaining <= w_lh - 16'd2;
          ST_TCTH: if (w_rem_nz) begin
            r_remaining <= r_remaining - 16'd1;
            if (w_tcth_ok) begin
              r_class  <= byte_in[4];
              r_id     <= byte_in[1:0];
              r_counts <= '0;
              r_vals   <= '0;
              r_idx    <= '0;
              r_total  <= '0;
            end
          end
          ST_COUNTS: if (w_rem_nz) begin
            r_remaining            <= r_remaining - 16'd1;
            r_counts[r_idx[CW-1:0]] <= byte_in;
            r_total                <= w_total_nxt;
            // Index restarts at 0 so the value phase writes from entry 0.
            r_idx                  <= w_last_cnt ? '0 : r_idx + VW'(1);
          end
          ST_VALS: if (w_rem_nz) begin
            r_remaining   <= r_remaining - 16'd1;
            r_vals[r_idx] <= byte_in;
            r_idx         <= r_idx + VW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dht_parser.sv
// tb_jpeg_dht_parser: directed scoreboard bench for jpeg_dht_parser.
// Expected tables are queued as bytes are driven and checked when tbl_valid
// rises; a consumer process acks after a programmable delay.
module tb_jpeg_dht_parser;
  import jpeg_pkg::*;

  localparam int NL = 16;
  localparam int MV = 162;

  typedef struct {
    logic              cls;
    logic [1:0]        id;
    logic [NL-1:0][7:0] cnt;
    logic [MV-1:0][7:0] val;
  } tbl_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               seg_start;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [NL-1:0][7:0] huff_count_out;
  logic [MV-1:0][7:0] huff_val_out;
  logic               tbl_class;
  logic [1:0]         tbl_id;
  logic               tbl_valid;
  logic               tbl_ack;
  logic               seg_done;
  logic               err;

  jpeg_dht_parser #(.MAX_VALS(MV), .NUM_LEN(NL)) dut (
    .clk(clk), .rst_n(rst_n), .seg_start(seg_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .huff_count_out(huff_count_out), .huff_val_out(huff_val_out),
    .tbl_class(tbl_class), .tbl_id(tbl_id), .tbl_valid(tbl_valid),
    .tbl_ack(tbl_ack), .seg_done(seg_done), .err(err)
  );

  always #5 clk = ~clk;

  tbl_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ack_delay = 2;
  int   rises = 0;
  int   seg_done_cnt = 0;
  bit   gaps = 0;

  task automatic check(input string tag, input logic [1295:0] obs, input logic [1295:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) if (seg_done === 1'b1) seg_done_cnt++;

  // Consumer: score each captured table, watch it stay frozen, then ack.
  initial begin : consumer
    tbl_t e;
    logic [NL-1:0][7:0] sc;
    logic [MV-1:0][7:0] sv;
    logic [2:0] sm;
    bit stable, rdy_low;
    tbl_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (tbl_valid === 1'b1) begin
        rises++;
        check("tbl_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tbl_class", tbl_class, e.cls);
          check("tbl_id", tbl_id, e.id);
          check("tbl_counts", huff_count_out, e.cnt);
          check("tbl_vals", huff_val_out, e.val);
        end
        sc = huff_count_out; sv = huff_val_out; sm = {tbl_class, tbl_id};
        stable = 1; rdy_low = 1;
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          if (tbl_valid !== 1'b1 || huff_count_out !== sc || huff_val_out !== sv ||
              {tbl_class, tbl_id} !== sm) stable = 0;
          if (byte_ready !== 1'b0) rdy_low = 0;
        end
        check("hold_stable", stable, 1'b1);
        check("hold_rdy_low", rdy_low, 1'b1);
        tbl_ack = 1'b1;
        @(negedge clk);
        tbl_ack = 1'b0;
        check("ack_drops_valid", tbl_valid, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at #1 after a rising edge.
  task automatic send(input logic [7:0] b);
    bit ok;
    logic rdy;
    if (gaps && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    byte_in = b; byte_valid = 1'b1; ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) begin ok = 1; break; end
    end
    byte_valid = 1'b0;
    if (!ok) check("send_timeout", ok, 1'b1);
  endtask

  task automatic seg_pulse();
    seg_start = 1'b1;
    @(posedge clk); #1;
    seg_start = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] lh);
    send(lh[15:8]);
    send(lh[7:0]);
  endtask

  // Sends TcTh and the 16 counts; when full, also the values and queues the table.
  task automatic send_tbl(input logic [7:0] tcth, input logic [NL-1:0][7:0] cnt,
                          input logic [7:0] vbase, input bit full);
    tbl_t e;
    int tot = 0;
    e.cls = tcth[4]; e.id = tcth[1:0]; e.cnt = cnt; e.val = '0;
    for (int i = 0; i < NL; i++) tot += int'(cnt[i]);
    if (full) begin
      for (int i = 0; i < tot; i++) e.val[i] = vbase + 8'(i);
      exp_q.push_back(e);
    end
    send(tcth);
    for (int i = 0; i < NL; i++) send(cnt[i]);
    if (full) for (int i = 0; i < tot; i++) send(vbase + 8'(i));
  endtask

  task automatic wait_seg_done(input int budget);
    bit ok = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (seg_done === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("seg_done_timeout", ok, 1'b1);
  endtask

  initial begin : stim
    int luma[16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int alt[16]  = '{0, 2, 1, 3, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [NL-1:0][7:0] c_dc, c_b, c_big;
    int sd0, r0;
    for (int i = 0; i < NL; i++) begin
      c_dc[i]  = 8'(luma[i]);
      c_b[i]   = 8'(alt[i]);
      c_big[i] = (i == NL - 1) ? 8'd13 : 8'd10;  // 15*10 + 13 = 163
    end
    rst_n = 1'b0; seg_start = 1'b0; byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_tbl_valid", tbl_valid, 1'b0);
    check("rst_seg_done", seg_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_class_id", {tbl_class, tbl_id}, 3'd0);
    check("rst_counts", huff_count_out, '0);
    check("rst_vals", huff_val_out, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Standard luma DC table: 2 + 1 + 16 + 12 = 31 bytes.
    sd0 = seg_done_cnt; r0 = rises;
    seg_pulse();
    send_len(16'h001F);
    send_tbl(8'h00, c_dc, 8'h00, 1);
    wait_seg_done(200);
    check("dc_seg_done_cnt", seg_done_cnt - sd0, 1);
    check("dc_tbl_cnt", rises - r0, 1);
    check("dc_count1", huff_count_out[1], 8'd1);
    check("dc_count2", huff_count_out[2], 8'd5);
    check("dc_val11", huff_val_out[11], 8'd11);

    // Two 29-byte tables in one segment: length 2 + 58 = 0x3C.
    sd0 = seg_done_cnt; r0 = rises;
    seg_pulse();
    send_len(16'h003C);
    send_tbl(8'h00, c_dc, 8'h00, 1);
    send_tbl(8'h11, c_b, 8'h20, 1);
    wait_seg_done(400);
    check("two_queue_empty_at_done", exp_q.size(), 0);
    check("two_seg_done_cnt", seg_done_cnt - sd0, 1);
    check("two_tbl_cnt", rises - r0, 2);

    // Counts summing to 163 exceed capacity.
    r0 = rises;
    seg_pulse();
    send_len(16'h0100);
    send_tbl(8'h00, c_big, 8'h00, 0);
    check("big_err", err, 1'b1);
    for (int i = 0; i < 5; i++) send(8'hA5);
    check("big_err_sticky", err, 1'b1);
    check("big_drain_ready", byte_ready, 1'b1);
    check("big_no_tbl", rises - r0, 0);
    seg_pulse();
    check("big_err_cleared", err, 1'b0);

    // Truncated: Lh=0x10 leaves room for TcTh and only 13 counts.
    r0 = rises;
    seg_pulse();
    send_len(16'h0010);
    send(8'h00);
    for (int i = 0; i < 13; i++) send(c_dc[i]);
    check("trunc_err_not_early", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("trunc_err", err, 1'b1);
    check("trunc_no_tbl", rises - r0, 0);

    // Random input gaps and a slow consumer.
    gaps = 1; ack_delay = 50;
    sd0 = seg_done_cnt; r0 = rises;
    seg_pulse();
    check("restart_err_cleared", err, 1'b0);
    send_len(16'h001F);
    send_tbl(8'h01, c_dc, 8'h40, 1);
    wait_seg_done(2000);
    check("gap_seg_done_cnt", seg_done_cnt - sd0, 1);
    check("gap_tbl_cnt", rises - r0, 1);
    gaps = 0; ack_delay = 2;

    // Asynchronous reset in the middle of the value phase.
    r0 = rises;
    seg_pulse();
    send_len(16'h001F);
    send(8'h13);
    for (int i = 0; i < NL; i++) send(c_dc[i]);
    for (int i = 0; i < 5; i++) send(8'(i));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_class_id", {tbl_class, tbl_id}, 3'd0);
    check("mid_rst_counts", huff_count_out, '0);
    check("mid_rst_vals", huff_val_out, '0);
    check("mid_rst_ready", byte_ready, 1'b0);
    check("mid_rst_valid", tbl_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_tbl", rises - r0, 0);

    // seg_start in the middle of the counts restarts the parse.
    sd0 = seg_done_cnt; r0 = rises;
    seg_pulse();
    send_len(16'h001F);
    send(8'h00);
    for (int i = 0; i < 8; i++) send(c_dc[i]);
    seg_pulse();
    send_len(16'h001F);
    send_tbl(8'h12, c_dc, 8'h80, 1);
    wait_seg_done(200);
    check("restart_tbl_cnt", rises - r0, 1);
    check("restart_seg_done_cnt", seg_done_cnt - sd0, 1);
    check("restart_queue_empty", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
